// File: rtl/udp_cmd_parser_pkg.sv
// Shared constants, state encoding and command word for the UDP command parser.
package udp_cmd_parser_pkg;

  localparam logic [7:0]  HDR0           = 8'h55;
  localparam logic [7:0]  HDR1           = 8'hAA;
  localparam logic [15:0] CMD_LEN        = 16'd8;
  localparam logic [31:0] SAMPLE_NUM_DEF = 32'd1000;
  localparam logic [31:0] SAMPLE_NUM_MAX = 32'd1_000_000;

  localparam logic [7:0] OP_SET_SAMPLE_NUM = 8'h01;
  localparam logic [7:0] OP_SET_TRIG       = 8'h02;
  localparam logic [7:0] OP_START          = 8'h10;
  localparam logic [7:0] OP_STOP           = 8'h11;

  // One-hot frame receive states
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    RECV  = 5'b00010,
    DRAIN = 5'b00100,
    CHECK = 5'b01000,
    EXEC  = 5'b10000
  } state_t;

  // Decoded command handed from the deframer to the executor
  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] arg;
  } cmd_t;

  // XOR of opcode and the four argument bytes
  function automatic logic [7:0] body_xor(input logic [39:0] body);
    return body[39:32] ^ body[31:24] ^ body[23:16] ^ body[15:8] ^ body[7:0];
  endfunction

endpackage

// File: rtl/udp_cmd_deframer.sv
// Captures 8-byte command frames from the UDP receive stream, rejects runt,
// oversize and wrong-length frames, and verifies header and checksum.
// Handshake: the input stream has no backpressure; every cycle with valid
// high carries one byte, and a frame is a maximal run of valid-high cycles.
// frame_good / frame_bad are single-cycle pulses; cmd is stable while
// frame_good is high.
module udp_cmd_deframer import udp_cmd_parser_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [7:0]  data,
  input  logic [15:0] length,
  output cmd_t        cmd,
  output logic        frame_good,
  output logic        frame_bad,
  output state_t      state
);

  logic [63:0] shreg;
  logic [3:0]  count;
  logic        ovf;
  logic        hdr_ok;
  logic        sum_ok;

  assign cmd    = '{opcode: shreg[47:40], arg: shreg[39:8]};
  assign hdr_ok = (shreg[63:56] == HDR0) && (shreg[55:48] == HDR1);
  assign sum_ok = (body_xor(shreg[47:8]) == shreg[7:0]);

  // Frame receive FSM: byte capture, framing errors and verdict pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
    end else begin
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            if (length == CMD_LEN) begin
              shreg <= {56'd0, data};
              count <= 4'd1;
              state <= RECV;
            end else begin
              state <= DRAIN;
            end
          end
        end
        RECV: begin
          if (valid) begin
            if (count == 4'd8) begin
              state <= DRAIN;
            end else begin
              shreg <= {shreg[55:0], data};
              count <= count + 4'd1;
            end
          end else if (count == 4'd8) begin
            state <= CHECK;
          end else begin
            frame_bad <= 1'b1;
            state     <= IDLE;
          end
        end
        DRAIN: begin
          if (!valid) begin
            frame_bad <= 1'b1;
            state     <= IDLE;
          end
        end
        CHECK: begin
          // Bytes arriving while a command is pending are dropped and the
          // new frame is drained as oversize once the command has executed.
          ovf <= valid;
          if (hdr_ok && sum_ok) frame_good <= 1'b1;
          else                  frame_bad  <= 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          ovf   <= 1'b0;
          state <= (valid || ovf) ? DRAIN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/udp_cmd_parser.sv
// Host command parser: decodes UDP command frames and drives the capture
// configuration plus the start/run controls, with a run interlock.
module udp_cmd_parser import udp_cmd_parser_pkg::*; (
  input  logic        rgmii_clk,
  input  logic        rst,
  input  logic        udp_rec_data_valid,
  input  logic [7:0]  udp_rec_rdata,
  input  logic [15:0] udp_rec_data_length,
  input  logic        ethernet_read_done,
  output logic [31:0] sample_num,
  output logic [7:0]  trig_mask,
  output logic [7:0]  trig_value,
  output logic        sample_run,
  output logic        start_posedge,
  output logic        cmd_ok,
  output logic        cmd_err,
  output logic [15:0] err_cnt
);

  cmd_t   cmd;
  logic   frame_good;
  logic   frame_bad;
  state_t rx_state;
  logic   done_q;
  logic   accept;
  logic   err_now;
  logic   done_rise;

  udp_cmd_deframer u_deframer (
    .clk        (rgmii_clk),
    .rst        (rst),
    .valid      (udp_rec_data_valid),
    .data       (udp_rec_rdata),
    .length     (udp_rec_data_length),
    .cmd        (cmd),
    .frame_good (frame_good),
    .frame_bad  (frame_bad),
    .state      (rx_state)
  );

  assign done_rise = ethernet_read_done & ~done_q;

  // Command acceptance: opcode legality, argument range and run interlock
  always_comb begin
    accept = 1'b0;
    if (frame_good) begin
      case (cmd.opcode)
        OP_SET_SAMPLE_NUM: accept = !sample_run && (cmd.arg != 32'd0) &&
                                    (cmd.arg <= SAMPLE_NUM_MAX);
        OP_SET_TRIG:       accept = !sample_run;
        OP_START:          accept = !sample_run;
        OP_STOP:           accept = 1'b1;
        default:           accept = 1'b0;
      endcase
    end
    err_now = frame_bad | (frame_good & ~accept);
  end

  // Executor: applies accepted commands, result pulses, run control
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      sample_num    <= SAMPLE_NUM_DEF;
      trig_mask     <= '0;
      trig_value    <= '0;
      sample_run    <= 1'b0;
      start_posedge <= 1'b0;
      cmd_ok        <= 1'b0;
      cmd_err       <= 1'b0;
      err_cnt       <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= ethernet_read_done;
      start_posedge <= 1'b0;
      cmd_ok        <= accept;
      cmd_err       <= err_now;
      if (err_now && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      // A START in the same cycle as a read-done edge keeps the run going.
      if (accept && cmd.opcode == OP_START) begin
        sample_run    <= 1'b1;
        start_posedge <= 1'b1;
      end else if (accept && cmd.opcode == OP_STOP) begin
        sample_run <= 1'b0;
      end else if (done_rise) begin
        sample_run <= 1'b0;
      end
      if (accept && cmd.opcode == OP_SET_SAMPLE_NUM) sample_num <= cmd.arg;
      if (accept && cmd.opcode == OP_SET_TRIG) begin
        trig_mask  <= cmd.arg[15:8];
        trig_value <= cmd.arg[7:0];
      end
    end
  end

endmodule

// File: tb/tb_udp_cmd_parser.sv
// Directed testbench for udp_cmd_parser with a result scoreboard.
module tb_udp_cmd_parser;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [7:0]  data;
  logic [15:0] len;
  logic        done;
  logic [31:0] sample_num;
  logic [7:0]  trig_mask;
  logic [7:0]  trig_value;
  logic        sample_run;
  logic        start_posedge;
  logic        cmd_ok;
  logic        cmd_err;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;
  logic [1:0]  exp_q[$];     // 2'b10 = cmd_ok expected, 2'b01 = cmd_err expected
  logic [15:0] exp_err = 16'd0;

  localparam logic [1:0] R_OK  = 2'b10;
  localparam logic [1:0] R_ERR = 2'b01;

  // Frames, left-aligned in 72 bits: byte i is f[71-8*i -: 8]
  localparam logic [71:0] F_SN2000  = 72'h55AA01000007D0D6_00;
  localparam logic [71:0] F_START   = 72'h55AA100000000010_00;
  localparam logic [71:0] F_STOP    = 72'h55AA110000000011_00;
  localparam logic [71:0] F_TRIG    = 72'h55AA020000F0A557_00;
  localparam logic [71:0] F_TRIGBAD = 72'h55AA020000F0A500_00;
  localparam logic [71:0] F_TRIG9   = 72'h55AA020000F0A557_33;
  localparam logic [71:0] F_SN0     = 72'h55AA010000000001_00;
  localparam logic [71:0] F_SNOVR   = 72'h55AA01000F42410D_00;
  localparam logic [71:0] F_SNMAX   = 72'h55AA01000F42400C_00;
  localparam logic [71:0] F_UNK     = 72'h55AA330000000033_00;

  udp_cmd_parser dut (
    .rgmii_clk           (clk),
    .rst                 (rst),
    .udp_rec_data_valid  (valid),
    .udp_rec_rdata       (data),
    .udp_rec_data_length (len),
    .ethernet_read_done  (done),
    .sample_num          (sample_num),
    .trig_mask           (trig_mask),
    .trig_value          (trig_value),
    .sample_run          (sample_run),
    .start_posedge       (start_posedge),
    .cmd_ok              (cmd_ok),
    .cmd_err             (cmd_err),
    .err_cnt             (err_cnt)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive n bytes back-to-back, then drop valid (sampled low at the next edge)
  task automatic send_frame(input logic [71:0] f, input int n, input logic [15:0] l);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b1;
      data  = f[71-8*i -: 8];
      len   = l;
    end
    @(negedge clk);
    valid = 1'b0;
    data  = 8'h00;
  endtask

  task automatic expect_result(input logic [1:0] r);
    exp_q.push_back(r);
    if (r == R_ERR && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
  endtask

  // Monitor: every result pulse is matched against the expected queue
  always @(negedge clk) begin
    if (!rst && (cmd_ok || cmd_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result ok=%0b err=%0b expected=none", cmd_ok, cmd_err);
      end else begin
        check("result", {30'd0, cmd_ok, cmd_err}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1; valid = 1'b0; data = 8'h00; len = 16'd0; done = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst_sample_num", sample_num, 32'd1000);
    check("rst_trig", {trig_mask, trig_value}, 16'h0000);
    check("rst_run_start", {sample_run, start_posedge, cmd_ok, cmd_err}, 4'b0000);
    check("rst_err_cnt", err_cnt, 16'd0);

    // SET_SAMPLE_NUM 2000 with exact latency
    expect_result(R_OK);
    send_frame(F_SN2000, 8, 16'd8);
    idle(2);
    check("sn_not_yet", sample_num, 32'd1000);
    idle(1);
    check("sn_2000", sample_num, 32'd2000);
    check("sn_err_cnt", err_cnt, 16'd0);
    idle(3);

    // START: one-cycle start pulse and run level
    expect_result(R_OK);
    send_frame(F_START, 8, 16'd8);
    idle(2);
    check("start_pre", start_posedge, 1'b0);
    idle(1);
    check("start_pulse", {start_posedge, sample_run}, 2'b11);
    idle(1);
    check("start_pulse_end", {start_posedge, sample_run}, 2'b01);
    idle(3);

    // Second START and SET_TRIG while running are rejected
    expect_result(R_ERR);
    send_frame(F_START, 8, 16'd8);
    idle(5);
    check("start2_err_cnt", err_cnt, exp_err);
    check("start2_run", sample_run, 1'b1);
    expect_result(R_ERR);
    send_frame(F_TRIG, 8, 16'd8);
    idle(5);
    check("trig_locked", {trig_mask, trig_value}, 16'h0000);
    check("trig_locked_cnt", err_cnt, exp_err);

    // STOP then SET_TRIG is applied
    expect_result(R_OK);
    send_frame(F_STOP, 8, 16'd8);
    idle(5);
    check("stop_run", sample_run, 1'b0);
    expect_result(R_OK);
    send_frame(F_TRIG, 8, 16'd8);
    idle(5);
    check("trig_set", {trig_mask, trig_value}, 16'hF0A5);

    // START again, then read-done edge clears the run
    expect_result(R_OK);
    send_frame(F_START, 8, 16'd8);
    idle(5);
    check("restart_run", sample_run, 1'b1);
    done = 1'b1;
    idle(1);
    check("done_clears_run", sample_run, 1'b0);
    done = 1'b0;
    idle(3);

    // Framing errors: bad checksum, length 9, oversize with length 8, runt
    expect_result(R_ERR);
    send_frame(F_TRIGBAD, 8, 16'd8);
    idle(4);
    expect_result(R_ERR);
    send_frame(F_TRIG9, 9, 16'd9);
    idle(4);
    expect_result(R_ERR);
    send_frame(F_TRIG9, 9, 16'd8);
    idle(4);
    expect_result(R_ERR);
    send_frame(F_SN2000, 5, 16'd8);
    idle(4);
    check("frame_err_cnt", err_cnt, exp_err);
    check("frame_err_cfg", {sample_num, trig_mask, trig_value}, {32'd2000, 16'hF0A5});

    // sample_num range boundaries and an unknown opcode
    expect_result(R_ERR);
    send_frame(F_SN0, 8, 16'd8);
    idle(4);
    expect_result(R_ERR);
    send_frame(F_SNOVR, 8, 16'd8);
    idle(4);
    check("sn_range_rej", sample_num, 32'd2000);
    expect_result(R_OK);
    send_frame(F_SNMAX, 8, 16'd8);
    idle(4);
    check("sn_max", sample_num, 32'd1_000_000);
    expect_result(R_ERR);
    send_frame(F_UNK, 8, 16'd8);
    idle(4);
    check("unk_err_cnt", err_cnt, exp_err);

    // Bytes during CHECK: command result first, then one error
    expect_result(R_OK);
    expect_result(R_ERR);
    send_frame(F_STOP, 8, 16'd8);
    send_frame(F_STOP, 3, 16'd8);
    idle(6);
    check("ovf_err_cnt", err_cnt, exp_err);

    // Reset after byte 4 of a frame
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid = 1'b1;
      data  = F_SN2000[71-8*i -: 8];
      len   = 16'd8;
    end
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    idle(2);
    rst = 1'b0;
    exp_err = 16'd0;
    idle(3);
    check("mid_rst_cfg", {sample_num, trig_mask, trig_value}, {32'd1000, 16'h0000});
    check("mid_rst_flags", {sample_run, start_posedge, cmd_ok, cmd_err}, 4'b0000);
    check("mid_rst_err_cnt", err_cnt, 16'd0);
    expect_result(R_OK);
    send_frame(F_SN2000, 8, 16'd8);
    idle(4);
    check("post_rst_sn", sample_num, 32'd2000);

    // Wait for any outstanding results, bounded
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
